// File: rtl/xorgate.sv
// ----------------------------------------------------------------------------
// xorgate
//
// Three-input XOR (odd-parity) leaf cell with a small clocked observation path.
//
// The parity result y is purely combinational from a, b, c and is valid with
// the clock stopped. Alongside it, three registered observers watch y:
//   - y_q      : y delayed by one rising edge
//   - acc      : running XOR of every y sampled since the last reset edge
//   - ones_cnt : saturating count of rising edges at which y was 1
//
// There is no handshake and no valid qualifier: every rising edge with rst=0
// samples y, and every rising edge with rst=1 clears the observers and throws
// the sampled y away.
//
// Parameters:
//   CNT_W     width of ones_cnt (must be at least 2)
//
// Ports:
//   clk       in   1      clock, all state changes on the rising edge
//   rst       in   1      synchronous active-high reset
//   a, b, c   in   1      parity operands
//   y         out  1      a ^ b ^ c, combinational, unaffected by clk/rst
//   y_q       out  1      y registered one edge later
//   acc       out  1      running parity of sampled y values
//   ones_cnt  out  CNT_W  saturating count of edges with y=1
// ----------------------------------------------------------------------------
module xorgate #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             y,
  output logic             y_q,
  output logic             acc,
  output logic [CNT_W-1:0] ones_cnt
);

  logic             w_y;
  logic             w_cnt_sat;
  logic             r_y_q;
  logic             r_acc;
  logic [CNT_W-1:0] r_ones_cnt;

  // No sanitising of X/Z: an unknown operand shows up as an unknown y.
  assign w_y = a ^ b ^ c;

  // All-ones is the ceiling; the counter holds there instead of wrapping.
  assign w_cnt_sat = &r_ones_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      // The reset edge wins over the sample taken on the same edge.
      r_y_q      <= 1'b0;
      r_acc      <= 1'b0;
      r_ones_cnt <= '0;
    end else begin
      r_y_q <= w_y;
      r_acc <= r_acc ^ w_y;
      if (w_y && !w_cnt_sat) begin
        r_ones_cnt <= r_ones_cnt + CNT_W'(1);
      end
    end
  end

  assign y        = w_y;
  assign y_q      = r_y_q;
  assign acc      = r_acc;
  assign ones_cnt = r_ones_cnt;

endmodule

// File: tb/tb_xorgate.sv
// ----------------------------------------------------------------------------
// tb_xorgate
//
// Drives two xorgate instances from the same inputs: one with the default
// 8-bit counter and one with CNT_W=2 so that saturation is reached quickly.
// Expected registered values come from a behavioural model that simply counts
// how many sampled y values were 1 since the last reset edge: acc is that
// count mod 2, ones_cnt is that count clipped to the counter maximum.
// ----------------------------------------------------------------------------
module tb_xorgate;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic       a, b, c;

  logic       y8, yq8, acc8;
  logic [7:0] cnt8;
  logic       y2, yq2, acc2;
  logic [1:0] cnt2;

  int n_vec;
  int n_err;

  // Behavioural model state
  int   m_total;  // ones sampled since the last reset edge, unbounded
  logic m_yq;

  xorgate #(.CNT_W(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .c        (c),
    .y        (y8),
    .y_q      (yq8),
    .acc      (acc8),
    .ones_cnt (cnt8)
  );

  xorgate #(.CNT_W(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .c        (c),
    .y        (y2),
    .y_q      (yq2),
    .acc      (acc2),
    .ones_cnt (cnt2)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clk    = 1'b0;
    clk_en = 1'b0;
    rst    = 1'b0;
    a      = 1'b0;
    b      = 1'b0;
    c      = 1'b0;
  end

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic parity3(input logic [2:0] v);
    return logic'($countones(v) % 2);
  endfunction

  function automatic int clip(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_total = 0;
      m_yq    = 1'b0;
    end else begin
      m_yq = parity3({a, b, c});
      if (m_yq) m_total = m_total + 1;
    end
  endtask

  // ---------------- driver ----------------
  // Drive inputs on the falling edge, take the rising edge, update the model,
  // and leave time at 1 unit after the edge for sampling.
  task automatic step(input logic [2:0] abc, input logic r);
    @(negedge clk);
    {a, b, c} = abc;
    rst       = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_comb_sweep();
    logic [7:0] tt;
    tt = 8'b1001_0110;  // y for {a,b,c} = 0..7, bit i is the entry for i
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = 3'(i);
      #4;
      n_vec++;
      if (y8 !== tt[i] || y2 !== tt[i]) begin
        n_err++;
        $display("FAIL comb_sweep abc=%03b y8=%b y2=%b expected %b", 3'(i), y8, y2, tt[i]);
      end
      #1;
    end
  endtask

  task automatic test_reset();
    step(3'b111, 1'b1);
    step(3'b111, 1'b1);
    n_vec++;
    if (y8 !== 1'b1 || y2 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_y y8=%b y2=%b expected 1", y8, y2);
    end
    n_vec++;
    if (yq8 !== 1'b0 || acc8 !== 1'b0 || cnt8 !== 8'd0 ||
        yq2 !== 1'b0 || acc2 !== 1'b0 || cnt2 !== 2'd0) begin
      n_err++;
      $display("FAIL reset_regs yq=%b/%b acc=%b/%b cnt=%0d/%0d expected all 0",
               yq8, yq2, acc8, acc2, cnt8, cnt2);
    end
  endtask

  task automatic test_registered();
    logic [2:0] pat   [4];
    logic       e_yq  [4];
    logic       e_acc [4];
    int         e_cnt [4];
    pat   = '{3'b001, 3'b011, 3'b111, 3'b000};
    e_yq  = '{1'b1, 1'b0, 1'b1, 1'b0};
    e_acc = '{1'b1, 1'b1, 1'b0, 1'b0};
    e_cnt = '{1, 1, 2, 2};
    step(3'b000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(pat[i], 1'b0);
      n_vec++;
      if (yq8 !== e_yq[i] || acc8 !== e_acc[i] || int'(cnt8) != e_cnt[i]) begin
        n_err++;
        $display("FAIL registered[%0d] yq=%b acc=%b cnt=%0d expected yq=%b acc=%b cnt=%0d",
                 i, yq8, acc8, cnt8, e_yq[i], e_acc[i], e_cnt[i]);
      end
    end
  endtask

  task automatic test_saturation2();
    int   e_cnt [5];
    logic e_acc [5];
    e_cnt = '{1, 2, 3, 3, 3};
    e_acc = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    step(3'b100, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(3'b100, 1'b0);
      n_vec++;
      if (int'(cnt2) != e_cnt[i] || acc2 !== e_acc[i] || yq2 !== 1'b1) begin
        n_err++;
        $display("FAIL saturation2[%0d] cnt=%0d acc=%b yq=%b expected cnt=%0d acc=%b yq=1",
                 i, cnt2, acc2, yq2, e_cnt[i], e_acc[i]);
      end
    end
  endtask

  task automatic test_saturation8();
    step(3'b010, 1'b1);
    for (int i = 0; i < 260; i++) begin
      step(3'b010, 1'b0);
      if (i == 253 || i == 254 || i == 259) begin
        n_vec++;
        if (int'(cnt8) != clip(m_total, 255) || acc8 !== logic'(m_total % 2)) begin
          n_err++;
          $display("FAIL saturation8 edge=%0d cnt=%0d acc=%b expected cnt=%0d acc=%b",
                   i + 1, cnt8, acc8, clip(m_total, 255), logic'(m_total % 2));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(3'b000, 1'b1);
    step(3'b100, 1'b0);
    step(3'b001, 1'b0);
    n_vec++;
    if (cnt8 !== 8'd2) begin
      n_err++;
      $display("FAIL reset_mid_pre cnt=%0d expected 2", cnt8);
    end
    step(3'b111, 1'b1);
    n_vec++;
    if (cnt8 !== 8'd0 || acc8 !== 1'b0 || yq8 !== 1'b0 || cnt2 !== 2'd0) begin
      n_err++;
      $display("FAIL reset_mid_clear cnt=%0d acc=%b yq=%b cnt2=%0d expected 0 0 0 0",
               cnt8, acc8, yq8, cnt2);
    end
    step(3'b111, 1'b0);
    n_vec++;
    if (cnt8 !== 8'd1 || acc8 !== 1'b1 || yq8 !== 1'b1 || cnt2 !== 2'd1) begin
      n_err++;
      $display("FAIL reset_mid_restart cnt=%0d acc=%b yq=%b cnt2=%0d expected 1 1 1 1",
               cnt8, acc8, yq8, cnt2);
    end
  endtask

  task automatic test_reset_async();
    // Bring the observers to a non-zero state first.
    step(3'b000, 1'b1);
    step(3'b001, 1'b0);
    step(3'b010, 1'b0);
    @(negedge clk);
    {a, b, c} = 3'b001;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if (yq8 !== m_yq || acc8 !== logic'(m_total % 2) || int'(cnt8) != m_total) begin
      n_err++;
      $display("FAIL reset_async_between yq=%b acc=%b cnt=%0d expected yq=%b acc=%b cnt=%0d",
               yq8, acc8, cnt8, m_yq, logic'(m_total % 2), m_total);
    end
    @(posedge clk);
    model_edge();
    #1;
    n_vec++;
    if (yq8 !== 1'b1 || acc8 !== 1'b1 || cnt8 !== 8'd3 || int'(cnt8) != m_total) begin
      n_err++;
      $display("FAIL reset_async_after yq=%b acc=%b cnt=%0d expected yq=1 acc=1 cnt=3",
               yq8, acc8, cnt8);
    end
  endtask

  task automatic test_random();
    logic [2:0] abc;
    logic       r;
    logic       ey;
    step(3'b000, 1'b1);
    for (int i = 0; i < 300; i++) begin
      abc = 3'($urandom_range(0, 7));
      r   = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      {a, b, c} = abc;
      rst       = r;
      #1;
      ey = parity3(abc);
      n_vec++;
      if (y8 !== ey || y2 !== ey) begin
        n_err++;
        $display("FAIL random_y[%0d] abc=%03b y8=%b y2=%b expected %b", i, abc, y8, y2, ey);
      end
      @(posedge clk);
      model_edge();
      #1;
      n_vec++;
      if (yq8 !== m_yq || yq2 !== m_yq ||
          acc8 !== logic'(m_total % 2) || acc2 !== logic'(m_total % 2) ||
          int'(cnt8) != clip(m_total, 255) || int'(cnt2) != clip(m_total, 3)) begin
        n_err++;
        $display("FAIL random_regs[%0d] yq=%b/%b acc=%b/%b cnt=%0d/%0d expected yq=%b acc=%b cnt=%0d/%0d",
                 i, yq8, yq2, acc8, acc2, cnt8, cnt2, m_yq, logic'(m_total % 2),
                 clip(m_total, 255), clip(m_total, 3));
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec   = 0;
    n_err   = 0;
    m_total = 0;
    m_yq    = 1'b0;
    #1;
    test_comb_sweep();   // clock still idle here
    clk_en = 1'b1;
    test_reset();
    test_registered();
    test_saturation2();
    test_saturation8();
    test_reset_mid();
    test_reset_async();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
